puf_resp_collector: RTL

- Initiator side of the RO-PUF challenge/response interface.
- Accepts a seed challenge from the host, then drives challenge pairs (chall0/chall1) to the two RO mux banks.
- Sequences RO enable, counter clear and the counting window, then compares the two returned counts.
- Shifts one response bit per pair into an N-bit response word and returns it over a valid/ready handshake.

---
 rtl/puf_pkg.sv | 22 ++
 rtl/puf_window_timer.sv | 27 ++
 rtl/puf_resp_collector.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/puf_pkg.sv
// Shared types and constants for the RO-PUF response collector.
package puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SETTLE,
    ST_COUNT,
    ST_STOP,
    ST_EVAL,
    ST_DONE
  } puf_state_e;

  localparam int unsigned DEF_CHALL_W    = 8;
  localparam int unsigned DEF_CNT_W      = 16;
  localparam int unsigned DEF_RESP_BITS  = 32;
  localparam int unsigned DEF_SETTLE_CYC = 4;
  localparam int unsigned DEF_WINDOW     = 1024;

  localparam int unsigned TIE_W = 8;

endpackage

// File: rtl/puf_window_timer.sv
// Loadable down-counter with terminal-count flag; holds at zero instead of wrapping.
module puf_window_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/puf_resp_collector.sv
// RO-PUF initiator: walks challenge pairs, times settle/count windows and
// assembles one response bit per pair into an LSB-first response word.
module puf_resp_collector
  import puf_pkg::*;
#(
  parameter int unsigned CHALL_W    = DEF_CHALL_W,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned RESP_BITS  = DEF_RESP_BITS,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned WINDOW     = DEF_WINDOW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CHALL_W-1:0]   seed,
  output logic [CHALL_W-1:0]   chall0,
  output logic [CHALL_W-1:0]   chall1,
  output logic                 roen,
  output logic                 cnten,
  output logic                 cntclr,
  input  logic [CNT_W-1:0]     count0,
  input  logic [CNT_W-1:0]     count1,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [RESP_BITS-1:0] resp,
  output logic [TIE_W-1:0]     tie_cnt
);

  localparam int unsigned TMAX = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned KW   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(RESP_BITS - 1);

  puf_state_e    state;
  logic [KW-1:0] k;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_en;
  logic          tmr_tc;

  // Timer is reloaded whenever the FSM is about to leave its current state,
  // so SETTLE and COUNT each start from a fresh value; all others park it at 0.
  always_comb begin
    tmr_load = 1'b1;
    tmr_val  = '0;
    tmr_en   = 1'b0;
    case (state)
      ST_CLEAR:  tmr_val = TW'(SETTLE_CYC - 1);
      ST_SETTLE: begin
        if (tmr_tc) begin
          tmr_val = TW'(WINDOW - 1);
        end else begin
          tmr_load = 1'b0;
          tmr_en   = 1'b1;
        end
      end
      ST_COUNT: begin
        if (!tmr_tc) begin
          tmr_load = 1'b0;
          tmr_en   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  puf_window_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      chall0     <= '0;
      chall1     <= '0;
      roen       <= 1'b0;
      cnten      <= 1'b0;
      cntclr     <= 1'b0;
      resp_valid <= 1'b0;
      resp       <= '0;
      tie_cnt    <= '0;
      k          <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state     <= ST_CLEAR;
            req_ready <= 1'b0;
            chall0    <= seed;
            chall1    <= seed + CHALL_W'(1);
            resp      <= '0;
            tie_cnt   <= '0;
            k         <= '0;
            cntclr    <= 1'b1;
          end
        end
        ST_CLEAR: begin
          cntclr <= 1'b0;
          roen   <= 1'b1;
          state  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (tmr_tc) begin
            cnten <= 1'b1;
            state <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (tmr_tc) begin
            roen  <= 1'b0;
            cnten <= 1'b0;
            state <= ST_STOP;
          end
        end
        ST_STOP: state <= ST_EVAL;
        ST_EVAL: begin
          resp[k] <= (count0 > count1);
          if ((count0 == count1) && (tie_cnt != '1)) begin
            tie_cnt <= tie_cnt + TIE_W'(1);
          end
          if (k == K_LAST) begin
            resp_valid <= 1'b1;
            state      <= ST_DONE;
          end else begin
            k      <= k + KW'(1);
            chall0 <= chall0 + CHALL_W'(2);
            chall1 <= chall1 + CHALL_W'(2);
            cntclr <= 1'b1;
            state  <= ST_CLEAR;
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
